// File: rtl/text_rom_pkg.sv
// Shared constants, reveal state type and the fixed message table for text_rom_multi.
package text_rom_pkg;

    localparam int CHAR_W  = 7;
    localparam logic [CHAR_W-1:0] SPACE_CODE = 7'h20;
    localparam int TBL_LEN = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REVEAL,
        ST_DONE
    } reveal_state_t;

    // Rows are left-justified and space padded; anything outside the table reads as a space.
    function automatic logic [CHAR_W-1:0] msg_char(input int msg, input int idx);
        logic [8*TBL_LEN-1:0] row;
        logic [7:0]           ch;
        case (msg)
            0:       row = {"SOLO MODE", {7{8'h20}}};
            1:       row = "MULTIPLAYER MODE";
            2:       row = {"GOAL!", {11{8'h20}}};
            3:       row = {"MISSED", {10{8'h20}}};
            default: row = {TBL_LEN{8'h20}};
        endcase
        if (idx < 0 || idx >= TBL_LEN) begin
            ch = 8'h20;
        end else begin
            ch = row[8*(TBL_LEN-1-idx) +: 8];
        end
        return ch[CHAR_W-1:0];
    endfunction

endpackage

// File: rtl/text_reveal_ctrl.sv
// Typewriter reveal sequencer: tick divider plus IDLE/REVEAL/DONE FSM producing rev_cnt.
// Reveal behaviour is built only with TEXT_ROM_TYPEWRITER_EN; otherwise the whole message is visible.
module text_reveal_ctrl
    import text_rom_pkg::*;
#(
    parameter int N_MSG   = 4,
    parameter int MSG_LEN = 32,
    parameter int RATE    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(N_MSG)-1:0]     msg_sel,
    input  logic                         start,
    input  logic                         tick,
    output logic [$clog2(MSG_LEN+1)-1:0] rev_cnt,
    output logic                         busy,
    output logic                         done
);

    localparam int CNT_W = $clog2(MSG_LEN+1);

`ifdef TEXT_ROM_TYPEWRITER_EN
    localparam int DIV_W = (RATE > 1) ? $clog2(RATE) : 1;

    reveal_state_t              state, state_n;
    logic [CNT_W-1:0]           rev_n;
    logic [DIV_W-1:0]           div, div_n;
    logic [$clog2(N_MSG)-1:0]   sel_q;
    logic                       restart;

    always_ff @(posedge clk) begin
        sel_q <= msg_sel;
        if (rst) begin
            state   <= ST_IDLE;
            rev_cnt <= '0;
            div     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            rev_cnt <= rev_n;
            div     <= div_n;
            busy    <= (state_n == ST_REVEAL);
            done    <= (state_n == ST_DONE);
        end
    end

    always_comb begin
        state_n = state;
        rev_n   = rev_cnt;
        div_n   = div;
        // Start wins over tick; a selection change only matters mid-reveal.
        restart = start || ((state == ST_REVEAL) && (msg_sel != sel_q));
        if (restart) begin
            state_n = ST_REVEAL;
            rev_n   = '0;
            div_n   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rev_n = '0;
                    div_n = '0;
                end
                ST_REVEAL: begin
                    if (tick) begin
                        if (div == DIV_W'(RATE-1)) begin
                            div_n = '0;
                            if (rev_cnt == CNT_W'(MSG_LEN-1)) begin
                                rev_n   = CNT_W'(MSG_LEN);
                                state_n = ST_DONE;
                            end else begin
                                rev_n = rev_cnt + 1'b1;
                            end
                        end else begin
                            div_n = div + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    rev_n = CNT_W'(MSG_LEN);
                    div_n = '0;
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end
`else
    logic unused_in;
    assign unused_in = ^{msg_sel, start, tick};
    assign rev_cnt   = CNT_W'(MSG_LEN);
    assign busy      = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= 1'b1;
        end
    end
`endif

endmodule

// File: rtl/text_rom_multi.sv
// Multi-message character ROM with registered lookup and optional typewriter reveal
// (reveal enabled by TEXT_ROM_TYPEWRITER_EN, see text_reveal_ctrl).
module text_rom_multi
    import text_rom_pkg::*;
#(
    parameter int N_MSG   = 4,
    parameter int MSG_LEN = 32,
    parameter int RATE    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(N_MSG)-1:0] msg_sel,
    input  logic [11:0]              char_xy,
    input  logic                     start,
    input  logic                     tick,
    output logic [CHAR_W-1:0]        char_code,
    output logic                     busy,
    output logic                     done
);

    localparam int CNT_W = $clog2(MSG_LEN+1);

    logic [CNT_W-1:0] rev_cnt;
    logic             visible;

    text_reveal_ctrl #(
        .N_MSG   (N_MSG),
        .MSG_LEN (MSG_LEN),
        .RATE    (RATE)
    ) u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .msg_sel (msg_sel),
        .start   (start),
        .tick    (tick),
        .rev_cnt (rev_cnt),
        .busy    (busy),
        .done    (done)
    );

    // Compare in int so power-of-two sizes do not produce constant comparisons.
    always_comb begin
        visible = (int'(msg_sel) < N_MSG) &&
                  (int'(char_xy) < MSG_LEN) &&
                  (int'(char_xy) < int'(rev_cnt));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            char_code <= SPACE_CODE;
        end else if (visible) begin
            char_code <= msg_char(int'(msg_sel), int'(char_xy));
        end else begin
            char_code <= SPACE_CODE;
        end
    end

endmodule

// File: tb/tb_text_rom_multi.sv
// Randomized bench for text_rom_multi against a tick-counting reference model.
module tb_text_rom_multi;

    localparam int N_MSG   = 5;
    localparam int MSG_LEN = 32;
    localparam int RATE    = 4;
    localparam int SEL_W   = $clog2(N_MSG);

    logic             clk = 1'b0;
    logic             rst, start, tick;
    logic [SEL_W-1:0] msg_sel;
    logic [11:0]      char_xy;
    logic [6:0]       char_code;
    logic             busy, done;

    int n_err = 0;
    int n_chk = 0;

    string msgs[4] = '{"SOLO MODE", "MULTIPLAYER MODE", "GOAL!", "MISSED"};

    // Model: reveal count is simply ticks-since-(re)start divided by RATE, capped.
    bit m_started;
    int m_ticks;
    int m_prev_sel;
    bit m_out_of_rst;

    always #5 clk = ~clk;

    text_rom_multi #(
        .N_MSG   (N_MSG),
        .MSG_LEN (MSG_LEN),
        .RATE    (RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .msg_sel   (msg_sel),
        .char_xy   (char_xy),
        .start     (start),
        .tick      (tick),
        .char_code (char_code),
        .busy      (busy),
        .done      (done)
    );

    function automatic int m_rev();
`ifdef TEXT_ROM_TYPEWRITER_EN
        int r;
        if (!m_started) return 0;
        r = m_ticks / RATE;
        return (r > MSG_LEN) ? MSG_LEN : r;
`else
        return MSG_LEN;
`endif
    endfunction

    function automatic bit m_busy();
`ifdef TEXT_ROM_TYPEWRITER_EN
        return m_started && (m_rev() < MSG_LEN);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_done();
`ifdef TEXT_ROM_TYPEWRITER_EN
        return m_started && (m_rev() == MSG_LEN);
`else
        return m_out_of_rst;
`endif
    endfunction

    function automatic int exp_char(int sel, int xy);
        string s;
        if (sel >= N_MSG || sel >= 4 || xy >= MSG_LEN || xy >= m_rev()) return 32'h20;
        s = msgs[sel];
        if (xy >= s.len()) return 32'h20;
        return int'(s[xy]);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit t, input int sel, input int xy);
        int  exp_c;
        bit  busy_pre;
        @(negedge clk);
        rst     = r;
        start   = s;
        tick    = t;
        msg_sel = SEL_W'(sel);
        char_xy = 12'(xy);
        exp_c    = r ? 32'h20 : exp_char(sel, xy);
        busy_pre = m_busy();
        if (r) begin
            m_started = 1'b0;
            m_ticks   = 0;
        end else if (s) begin
            m_started = 1'b1;
            m_ticks   = 0;
        end else if (busy_pre && sel != m_prev_sel) begin
            m_ticks = 0;
        end else if (m_started && t && m_ticks < MSG_LEN*RATE) begin
            m_ticks++;
        end
        m_prev_sel   = sel;
        m_out_of_rst = !r;
        @(posedge clk);
        #1;
        check_val("char_code", 32'(char_code), exp_c);
        check_val("busy", 32'(busy), 32'(m_busy()));
        check_val("done", 32'(done), 32'(m_done()));
    endtask

    initial begin
        bit r, s, t;
        int sel, xy;
        rst = 1'b1; start = 1'b0; tick = 1'b0; msg_sel = '0; char_xy = '0;
        m_started = 1'b0; m_ticks = 0; m_prev_sel = 0; m_out_of_rst = 1'b0;

        // Reset with start and tick asserted: both must be ignored.
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
        check_val("rst_space", 32'(char_code), 32'h20);

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 9);
`ifndef TEXT_ROM_TYPEWRITER_EN
        check_val("solo_xy9_space", 32'(char_code), 32'h20);
        step(0, 0, 0, 0, 0);
        check_val("solo_s_now", 32'(char_code), 32'h53);
        check_val("done_now", 32'(done), 32'h1);
`endif

        // Start message 0 and deliver 8 ticks: two characters revealed.
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0, i % 3);
            step(0, 0, 0, 0, 1);
        end
        step(0, 0, 0, 0, 1);
`ifdef TEXT_ROM_TYPEWRITER_EN
        check_val("rev2_o", 32'(char_code), 32'h4F);
`endif
        step(0, 0, 0, 0, 2);
`ifdef TEXT_ROM_TYPEWRITER_EN
        check_val("rev2_space", 32'(char_code), 32'h20);
        check_val("rev2_busy", 32'(busy), 32'h1);
`endif

        // Start and tick together mid-reveal, then reset mid-reveal.
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Message 2 to completion, then extra ticks and a selection change in DONE.
        step(0, 1, 0, 2, 0);
        for (int i = 0; i < 5*RATE; i++) step(0, 0, 1, 2, i % 6);
        step(0, 0, 0, 2, 4);
`ifdef TEXT_ROM_TYPEWRITER_EN
        check_val("goal_bang", 32'(char_code), 32'h21);
`endif
        for (int i = 0; i < (MSG_LEN-5)*RATE + 8; i++) step(0, 0, 1, 2, i % 40);
        step(0, 0, 0, 3, 0);
        step(0, 0, 0, 3, 1);

        // Out-of-range selection and index.
        step(0, 0, 0, 7, 40);
        step(0, 0, 0, 7, 0);
        step(0, 0, 0, 0, 40);
        step(0, 0, 0, 4, 1);

        // Selection change during reveal restarts it.
        step(0, 1, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 1, i);
        step(0, 0, 1, 3, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 3, i);

        // Randomized traffic.
        sel = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 59) == 0);
            t = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 39) == 0) sel = $urandom_range(0, 7);
            xy = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 40);
            step(r, s, t, sel, xy);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
